uart_tx_cfg: RTL and testbench

Runtime-configurable UART transmitter. It serialises DLEN-bit words from a valid/ready stream onto a single TX line. Baud divisor, parity mode and stop-bit count are set per frame from control inputs. It sits between a bus-side register block or FIFO and the pad, and generalises the fixed-rate, fixed-format transmitter.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_baud_gen.sv | 36 +++
 rtl/uart_tx_cfg.sv | 187 ++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types: FSM state encoding, parity modes and the idle line level.
// Latency: none, types and constants only.
// Backpressure: not applicable.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_e;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Map the raw 2-bit control field onto a parity mode; 2'b11 also means none.
  function automatic parity_e decode_parity(input logic [1:0] mode);
    case (mode)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick generator: latched divisor, counter 0..max(div,1)-1, tick on the last count.
// Latency: tick is combinational from the counter; a cleared counter ticks after max(div,1) cycles.
// Backpressure: none; clr_i holds the counter at zero.
module uart_baud_gen #(
  parameter int DIVW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [DIVW-1:0] div_i,
  input  logic            clr_i,
  output logic            tick_o
);

  logic [DIVW-1:0] div_q;
  logic [DIVW-1:0] cnt_q;
  logic [DIVW-1:0] cnt_d;
  logic [DIVW-1:0] lim;

  // A divisor of zero behaves like one: the limit saturates at zero.
  assign lim    = (div_q == '0) ? '0 : div_q - DIVW'(1);
  assign tick_o = (cnt_q == lim);
  assign cnt_d  = (clr_i || tick_o) ? '0 : cnt_q + DIVW'(1);

  // Divisor latches only when a frame is accepted; counter wraps on every tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      if (load_i) div_q <= div_i;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter (divisor, parity, stop bits latched per frame).
// Latency: o_txs drops on the accept edge; frame = max(div,1)*(1+DLEN+P+S) cycles.
// Backpressure: o_ready in IDLE and in the last stop-bit tick cycle (back-to-back frames).
// Build option: define UART_TX_CFG_PARITY_EN to compile in the parity bit.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DLEN = 8,
  parameter int DIVW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DIVW-1:0] i_div,
  input  logic [1:0]      i_parity,
  input  logic            i_stop2,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [DLEN-1:0] i_data,
  output logic            o_txs,
  output logic            o_busy,
  output logic            o_done
);

  localparam int BW = $clog2(DLEN + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DLEN - 1);

  state_e          state_q;
  logic [DLEN-1:0] shreg_q;
  logic [BW-1:0]   bit_cnt_q;
  logic            stop2_q;
  logic            txs_q;
  logic            busy_q;
  logic            done_q;
  logic            tick;
  logic            accept;
  logic            last_stop;

`ifdef UART_TX_CFG_PARITY_EN
  logic            par_en_q;
  logic            par_odd_q;
  logic            par_acc_q;
  parity_e         par_mode;

  assign par_mode = decode_parity(i_parity);
`else
  logic            unused_parity;

  assign unused_parity = ^i_parity;
`endif

  // Counter is held at zero while idle and wraps on each tick, so every
  // state change (all of which happen on a tick or on accept) restarts it.
  uart_baud_gen #(
    .DIVW (DIVW)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .load_i (accept),
    .div_i  (i_div),
    .clr_i  (state_q == IDLE),
    .tick_o (tick)
  );

  assign last_stop = !stop2_q || (bit_cnt_q == BW'(1));
  assign o_ready   = (state_q == IDLE) || ((state_q == STOP) && tick && last_stop);
  assign accept    = i_valid && o_ready;

  assign o_txs  = txs_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

  // Frame sequencer; line, busy and done are registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      stop2_q   <= 1'b0;
      txs_q     <= UART_IDLE_LEVEL;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_CFG_PARITY_EN
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      par_acc_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;

      // Per-frame configuration is captured only on the accept edge.
      if (accept) begin
        shreg_q <= i_data;
        stop2_q <= i_stop2;
`ifdef UART_TX_CFG_PARITY_EN
        par_en_q  <= (par_mode != PAR_NONE);
        par_odd_q <= (par_mode == PAR_ODD);
`endif
      end

      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q   <= START;
            txs_q     <= ~UART_IDLE_LEVEL;
            busy_q    <= 1'b1;
            bit_cnt_q <= '0;
          end
        end

        START: begin
          if (tick) begin
            state_q   <= DATA;
            txs_q     <= shreg_q[0];
            shreg_q   <= shreg_q >> 1;
            bit_cnt_q <= '0;
`ifdef UART_TX_CFG_PARITY_EN
            par_acc_q <= shreg_q[0];
`endif
          end
        end

        DATA: begin
          if (tick) begin
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_q <= '0;
`ifdef UART_TX_CFG_PARITY_EN
              if (par_en_q) begin
                state_q <= PARITY;
                txs_q   <= par_acc_q ^ par_odd_q;
              end else begin
                state_q <= STOP;
                txs_q   <= UART_IDLE_LEVEL;
              end
`else
              state_q <= STOP;
              txs_q   <= UART_IDLE_LEVEL;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + BW'(1);
              txs_q     <= shreg_q[0];
              shreg_q   <= shreg_q >> 1;
`ifdef UART_TX_CFG_PARITY_EN
              par_acc_q <= par_acc_q ^ shreg_q[0];
`endif
            end
          end
        end

`ifdef UART_TX_CFG_PARITY_EN
        PARITY: begin
          if (tick) begin
            state_q   <= STOP;
            txs_q     <= UART_IDLE_LEVEL;
            bit_cnt_q <= '0;
          end
        end
`endif

        STOP: begin
          if (tick) begin
            if (!last_stop) begin
              bit_cnt_q <= bit_cnt_q + BW'(1);
            end else begin
              done_q    <= 1'b1;
              bit_cnt_q <= '0;
              if (accept) begin
                state_q <= START;
                txs_q   <= ~UART_IDLE_LEVEL;
              end else begin
                state_q <= IDLE;
                txs_q   <= UART_IDLE_LEVEL;
                busy_q  <= 1'b0;
              end
            end
          end
        end

        default: begin
          state_q <= IDLE;
          txs_q   <= UART_IDLE_LEVEL;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: per-cycle line/busy/ready/done against expected frames.
// Latency: frame lengths checked against hand-computed cycle counts.
// Backpressure: exercises idle accept, back-to-back accept and mid-frame reset.
module tb_uart_tx_cfg;

  localparam int DLEN = 8;
  localparam int DIVW = 16;
`ifdef UART_TX_CFG_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [DIVW-1:0] i_div;
  logic [1:0]      i_parity;
  logic            i_stop2;
  logic            i_valid;
  logic            o_ready;
  logic [DLEN-1:0] i_data;
  logic            o_txs;
  logic            o_busy;
  logic            o_done;

  int n_tests = 0;
  int n_fail  = 0;

  logic exp_txs[$];
  logic exp_rdy[$];
  logic exp_done[$];

  always #5 clk = ~clk;

  uart_tx_cfg #(
    .DLEN (DLEN),
    .DIVW (DIVW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_div    (i_div),
    .i_parity (i_parity),
    .i_stop2  (i_stop2),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_data   (i_data),
    .o_txs    (o_txs),
    .o_busy   (o_busy),
    .o_done   (o_done)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Append the expected line waveform of one frame, nc cycles per bit.
  task automatic add_frame(input logic [7:0] d, input int nc, input logic [1:0] pm, input logic s2);
    logic bits[$];
    logic p;
    p = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < DLEN; i++) begin
      bits.push_back(d[i]);
      p ^= d[i];
    end
    if (PAR_BUILT && pm == 2'b01) bits.push_back(p);
    if (PAR_BUILT && pm == 2'b10) bits.push_back(~p);
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    for (int b = 0; b < bits.size(); b++) begin
      for (int c = 0; c < nc; c++) begin
        exp_done.push_back(exp_txs.size() > 0 && b == 0 && c == 0);
        exp_txs.push_back(bits[b]);
        exp_rdy.push_back(b == bits.size() - 1 && c == nc - 1);
      end
    end
  endtask

  // Present a word at a negedge, let it be accepted, then disturb the controls.
  task automatic start(input logic [7:0] d, input logic [15:0] dv, input logic [1:0] pm,
                       input logic s2, input logic keep, input logic [15:0] dv_after);
    check("rdy_before_accept", o_ready, 1);
    i_data   = d;
    i_div    = dv;
    i_parity = pm;
    i_stop2  = s2;
    i_valid  = 1'b1;
    @(posedge clk);
    #1;
    if (!keep) begin
      i_valid  = 1'b0;
      i_data   = ~d;
      i_parity = ~pm;
      i_stop2  = ~s2;
    end
    i_div = dv_after;
  endtask

  // Walk the expected waveform cycle by cycle, then check the idle cycle after it.
  task automatic run(input string tag, input int hand_len, input int drop_at,
                     input int probe_at, output logic probe);
    int first_done;
    first_done = -1;
    probe = 1'b1;
    for (int i = 0; i < exp_txs.size(); i++) begin
      @(negedge clk);
      check({tag, ":txs"}, o_txs, exp_txs[i]);
      check({tag, ":busy"}, o_busy, 1);
      check({tag, ":rdy"}, o_ready, exp_rdy[i]);
      check({tag, ":done"}, o_done, exp_done[i]);
      if (o_done && first_done < 0) first_done = i;
      if (i == probe_at) probe = o_txs;
      if (i == drop_at) i_valid = 1'b0;
    end
    @(negedge clk);
    if (o_done && first_done < 0) first_done = exp_txs.size();
    check({tag, ":end_txs"}, o_txs, 1);
    check({tag, ":end_busy"}, o_busy, 0);
    check({tag, ":end_done"}, o_done, 1);
    check({tag, ":end_rdy"}, o_ready, 1);
    check({tag, ":len"}, first_done, hand_len);
    exp_txs.delete();
    exp_rdy.delete();
    exp_done.delete();
  endtask

  initial begin
    logic pr;
    i_valid  = 1'b0;
    i_data   = '0;
    i_div    = 16'd4;
    i_parity = 2'b00;
    i_stop2  = 1'b0;
    rst      = 1'b1;

    @(negedge clk);
    check("rst_txs", o_txs, 1);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_rdy", o_ready, 1);
    rst = 1'b0;

    // 0xA5, div 4, no parity, one stop: 40 cycles
    add_frame(8'hA5, 4, 2'b00, 1'b0);
    start(8'hA5, 16'd4, 2'b00, 1'b0, 1'b0, 16'd4);
    run("a5_none", 40, -1, -1, pr);

    // Even parity: XOR(0xA5)=0, parity bit sits in cycles 36..39
    add_frame(8'hA5, 4, 2'b01, 1'b0);
    start(8'hA5, 16'd4, 2'b01, 1'b0, 1'b0, 16'd4);
    run("a5_even", PAR_BUILT ? 44 : 40, -1, 37, pr);
    check("a5_even_bit", pr, PAR_BUILT ? 0 : 1);

    // Odd parity: parity bit 1
    add_frame(8'hA5, 4, 2'b10, 1'b0);
    start(8'hA5, 16'd4, 2'b10, 1'b0, 1'b0, 16'd4);
    run("a5_odd", PAR_BUILT ? 44 : 40, -1, 37, pr);
    check("a5_odd_bit", pr, 1);

    // Two stop bits, div 3, data 0x00: 11 bits x 3 = 33 cycles, stop high cycles 27..32
    add_frame(8'h00, 3, 2'b00, 1'b1);
    start(8'h00, 16'd3, 2'b00, 1'b1, 1'b0, 16'd3);
    run("stop2", 33, -1, 27, pr);
    check("stop2_first_stop", pr, 1);

    // Back-to-back 0x01 then 0x80 at div 2: second start right after first stop
    add_frame(8'h01, 2, 2'b00, 1'b0);
    add_frame(8'h80, 2, 2'b00, 1'b0);
    start(8'h01, 16'd2, 2'b00, 1'b0, 1'b1, 16'd2);
    i_data = 8'h80;
    run("b2b", 20, 20, 20, pr);
    check("b2b_second_start", pr, 0);

    // Divisor changed to 8 mid-frame: this frame keeps 4, the next uses 8
    add_frame(8'h3C, 4, 2'b00, 1'b0);
    start(8'h3C, 16'd4, 2'b00, 1'b0, 1'b0, 16'd8);
    run("div4_kept", 40, -1, -1, pr);
    add_frame(8'hC3, 8, 2'b00, 1'b0);
    start(8'hC3, 16'd8, 2'b00, 1'b0, 1'b0, 16'd8);
    run("div8_next", 80, -1, -1, pr);

    // Divisor 0 behaves as 1: 10-cycle frame
    add_frame(8'h5A, 1, 2'b00, 1'b0);
    start(8'h5A, 16'd0, 2'b00, 1'b0, 1'b0, 16'd0);
    run("div0", 10, -1, -1, pr);

    // Reset during data bit 3 (cycles 16..19) of 0xA5 at div 4
    start(8'hA5, 16'd4, 2'b00, 1'b0, 1'b0, 16'd4);
    repeat (18) @(negedge clk);
    check("mid_bit3_txs", o_txs, 0);
    rst = 1'b1;
    #1;
    check("arst_txs", o_txs, 1);
    check("arst_rdy", o_ready, 1);
    check("arst_busy", o_busy, 0);
    check("arst_done", o_done, 0);
    @(negedge clk);
    check("arst_hold_done", o_done, 0);
    check("arst_hold_txs", o_txs, 1);
    rst = 1'b0;
    add_frame(8'hC3, 2, 2'b00, 1'b0);
    start(8'hC3, 16'd2, 2'b00, 1'b0, 1'b0, 16'd2);
    run("after_rst", 20, -1, -1, pr);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
